lock_client_agent: RTL and testbench
====================================

Name: lock_client_agent

Overview:
- Per-core initiator for the shared-accelerator lock protocol. One instance sits between each core and its client port on the lock arbiter.
- On a core request it acquires the lock:
  - writes 1 to LOCK_ADDR;
  - polls the LOCK_ADDR readback until it returns CLIENT_ID, with bounded retry and backoff.
- While the lock is owned, it passes core accelerator accesses through.
- On a core release it writes 0 to LOCK_ADDR.

Parameters:
- CLIENT_ID, 0, this core's index on the lock arbiter (0..N_CLIENTS-1).
- N_CLIENTS, 2, number of clients; a LOCK_ADDR readback equal to N_CLIENTS means the lock is free.
- LOCK_ADDR, 32'd84, address of the lock register.
- BACKOFF_CYCLES, 4, idle cycles between a failed check and the next attempt; must be ≥1.
- MAX_RETRIES, 8, failed attempts allowed before giving up; must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- acq_req_i  in  1  single-cycle pulse: acquire the lock
- rel_req_i  in  1  single-cycle pulse: release the lock, or abort an acquisition in progress
- granted_o  out  1  high while the lock is owned
- busy_o  out  1  high in any state other than IDLE and OWNED
- fail_o  out  1  one-cycle pulse when MAX_RETRIES is exhausted
- attempts_o  out  8  attempt count for the current acquisition, saturating at 255
- core_addr_i  in  32  core access address
- core_wr_en_i  in  1  core write enable
- core_select_i  in  1  core select
- core_data_i  in  32  core write data
- core_data_o  out  32  read data returned to the core
- bus_addr_o  out  32  address to the lock client port
- bus_wr_en_o  out  1  write enable to the lock client port
- bus_select_o  out  1  select to the lock client port
- bus_data_o  out  32  write data to the lock client port
- bus_data_i  in  32  read data from the lock port; combinational, valid in the same cycle as the address

Behaviour:
- Reset (asynchronous):
  - state=IDLE; retry count=0; backoff count=0; attempts_o=0.
  - All outputs 0.
- Bus idle value (used when a state below says "idle"): bus_addr_o=0, bus_wr_en_o=0, bus_select_o=0, bus_data_o=0.
- States:
  - IDLE: bus idle; core_data_o=0.
    - acq_req_i → REQ; clear retry count; attempts_o=0.
    - rel_req_i is ignored.
  - REQ: drive addr=LOCK_ADDR, wr_en=1, select=1, data=32'd1 for exactly one cycle.
    - attempts_o increments (saturating at 255).
    - → CHECK.
  - CHECK: drive addr=LOCK_ADDR, wr_en=0, select=1; sample bus_data_i.
    - bus_data_i==CLIENT_ID: if rel_req_i is also asserted → RELEASE, else → OWNED.
    - Otherwise: retry count+1.
      - If retry count+1==MAX_RETRIES → IDLE and pulse fail_o.
      - Else → BACKOFF, loading backoff count=BACKOFF_CYCLES-1.
  - BACKOFF: bus idle.
    - Count down; at 0 → REQ.
    - rel_req_i → IDLE with no bus write (lock not owned); fail_o is not pulsed.
  - OWNED: granted_o=1; bus outputs = core_* inputs; core_data_o=bus_data_i.
    - rel_req_i → RELEASE. It takes priority over the core access in that same cycle, which is still forwarded.
    - acq_req_i is ignored.
  - RELEASE: drive addr=LOCK_ADDR, wr_en=1, select=1, data=0 for one cycle; granted_o=0.
    - → IDLE.
- Latency:
  - Uncontended acquisition: acq_req_i pulse at cycle t; granted_o=1 from cycle t+3 (REQ at t+1, CHECK at t+2, OWNED at t+3).
  - Release: rel_req_i at t; RELEASE at t+1; IDLE at t+2.
- Simultaneous acq_req_i and rel_req_i in IDLE: acquire wins.
- acq_req_i in any non-IDLE state: ignored.
- busy_o=1 in REQ, CHECK, BACKOFF and RELEASE.
- core_data_o=0 in every state except OWNED.
- Widths:
  - Retry counter: $clog2(MAX_RETRIES+1) bits.
  - Backoff counter: $clog2(BACKOFF_CYCLES+1) bits.
  - CLIENT_ID is compared against all 32 bits of bus_data_i.
- Reset mid-OWNED: the agent returns to IDLE and no release write is issued. The arbiter owns its own reset.

Decomposition:
- Shared package lock_pkg:
  - state enum: IDLE, REQ, CHECK, BACKOFF, OWNED, RELEASE;
  - LOCK_ADDR default;
  - constants LOCK_ACQ_VAL=32'd1 and LOCK_REL_VAL=32'd0.
- Natural sub-module lock_backoff_ctr: loadable down-counter with load and done signals. Everything else stays flat.

Test Plan:
1. Free lock (model returns 2, then 0 after the write of 1); acq pulse at cycle 0 → REQ bus write {84, wr=1, data=1} at cycle 1; granted_o=1 at cycle 3; attempts_o=1.
2. Lock held by client 1 (readback 1), MAX_RETRIES=3, BACKOFF_CYCLES=4 → three REQ writes spaced 6 cycles apart; fail_o pulses once; state returns to IDLE; granted_o never asserts.
3. Owned; core writes {addr 0x10, data 0xDEAD} → bus mirrors the access exactly; core read returns bus_data_i=0x1234 on core_data_o in the same cycle.
4. Owned; rel_req_i pulse → next cycle bus {84, wr=1, data=0}; granted_o drops to 0 in that cycle; IDLE after it.
5. rel_req_i during BACKOFF → IDLE next cycle; no write to LOCK_ADDR; fail_o=0.
6. Assert rst_n=0 asynchronously mid-OWNED → all outputs 0 immediately; a subsequent acq pulse follows scenario 1 timing.

Source files
------------

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and constants for the lock protocol
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    CHECK   = 3'd2,
    BACKOFF = 3'd3,
    OWNED   = 3'd4,
    RELEASE = 3'd5
  } lock_state_e;

  localparam logic [31:0] LOCK_ADDR_DEFAULT = 32'd84;
  localparam logic [31:0] LOCK_ACQ_VAL      = 32'd1;
  localparam logic [31:0] LOCK_REL_VAL      = 32'd0;

  // Saturating 8-bit increment, used by the attempt counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lock_backoff_ctr.sv
// rtl/lock_backoff_ctr.sv - loadable down-counter timing the retry backoff
module lock_backoff_ctr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         done
);

  // Load wins over counting; the count parks at zero once reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lock_client_agent.sv
// rtl/lock_client_agent.sv - per-core initiator that acquires, uses and releases the shared lock
module lock_client_agent
  import lock_pkg::*;
#(
  parameter int unsigned CLIENT_ID      = 0,
  parameter int unsigned N_CLIENTS      = 2,
  parameter logic [31:0] LOCK_ADDR      = LOCK_ADDR_DEFAULT,
  parameter int unsigned BACKOFF_CYCLES = 4,
  parameter int unsigned MAX_RETRIES    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acq_req_i,
  input  logic        rel_req_i,
  output logic        granted_o,
  output logic        busy_o,
  output logic        fail_o,
  output logic [7:0]  attempts_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_wr_en_i,
  input  logic        core_select_i,
  input  logic [31:0] core_data_i,
  output logic [31:0] core_data_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_wr_en_o,
  output logic        bus_select_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i
);

  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned BW = $clog2(BACKOFF_CYCLES + 1);

  // A free lock reads back N_CLIENTS, so a valid client index is always below it
  if (CLIENT_ID >= N_CLIENTS) begin : g_bad_client_id
    $error("CLIENT_ID must be below N_CLIENTS");
  end
  if (BACKOFF_CYCLES < 1) begin : g_bad_backoff
    $error("BACKOFF_CYCLES must be at least 1");
  end
  if (MAX_RETRIES < 1) begin : g_bad_retries
    $error("MAX_RETRIES must be at least 1");
  end

  lock_state_e   state_q, state_d;
  logic [RW-1:0] retry_q;
  logic [RW-1:0] retry_inc;
  logic [7:0]    attempts_q;
  logic          fail_q;
  logic          hit;
  logic          exhausted;
  logic          bo_load;
  logic          bo_en;
  logic          bo_done;
  logic [BW-1:0] bo_count;

  // Readback is compared over the full 32-bit word
  assign hit       = (bus_data_i == 32'(CLIENT_ID));
  assign retry_inc = retry_q + 1'b1;
  assign exhausted = (retry_inc == RW'(MAX_RETRIES));
  assign bo_load   = (state_q == CHECK) && !hit && !exhausted;
  assign bo_en     = (state_q == BACKOFF);

  lock_backoff_ctr #(.W(BW)) u_backoff (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bo_load),
    .load_val (BW'(BACKOFF_CYCLES - 1)),
    .en       (bo_en),
    .count    (bo_count),
    .done     (bo_done)
  );

  // State register; an asynchronous reset abandons ownership without a release write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Retry and attempt bookkeeping, plus the registered give-up pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q    <= '0;
      attempts_q <= '0;
      fail_q     <= 1'b0;
    end else begin
      fail_q <= (state_q == CHECK) && !hit && exhausted;
      if ((state_q == IDLE) && acq_req_i) begin
        retry_q    <= '0;
        attempts_q <= '0;
      end else if (state_q == REQ) begin
        attempts_q <= sat_inc8(attempts_q);
      end else if (bo_load) begin
        retry_q <= retry_inc;
      end
    end
  end

  // Next-state logic; acquire requests outside IDLE are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acq_req_i) state_d = REQ;
      REQ:     state_d = CHECK;
      CHECK: begin
        if (hit)            state_d = rel_req_i ? RELEASE : OWNED;
        else if (exhausted) state_d = IDLE;
        else                state_d = BACKOFF;
      end
      BACKOFF: begin
        if (rel_req_i)    state_d = IDLE;
        else if (bo_done) state_d = REQ;
      end
      OWNED:   if (rel_req_i) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; the bus idles at zero unless a state drives it
  always_comb begin
    granted_o    = 1'b0;
    busy_o       = 1'b0;
    core_data_o  = '0;
    bus_addr_o   = '0;
    bus_wr_en_o  = 1'b0;
    bus_select_o = 1'b0;
    bus_data_o   = '0;
    case (state_q)
      REQ: begin
        busy_o       = 1'b1;
        bus_addr_o   = LOCK_ADDR;
        bus_wr_en_o  = 1'b1;
        bus_select_o = 1'b1;
        bus_data_o   = LOCK_ACQ_VAL;
      end
      CHECK: begin
        busy_o       = 1'b1;
        bus_addr_o   = LOCK_ADDR;
        bus_select_o = 1'b1;
      end
      BACKOFF: busy_o = 1'b1;
      OWNED: begin
        granted_o    = 1'b1;
        bus_addr_o   = core_addr_i;
        bus_wr_en_o  = core_wr_en_i;
        bus_select_o = core_select_i;
        bus_data_o   = core_data_i;
        core_data_o  = bus_data_i;
      end
      RELEASE: begin
        busy_o       = 1'b1;
        bus_addr_o   = LOCK_ADDR;
        bus_wr_en_o  = 1'b1;
        bus_select_o = 1'b1;
        bus_data_o   = LOCK_REL_VAL;
      end
      default: ;
    endcase
  end

  assign fail_o     = fail_q;
  assign attempts_o = attempts_q;

endmodule

// File: tb/tb_lock_client_agent.sv
// tb/tb_lock_client_agent.sv - self-checking bench for lock_client_agent with an arbiter model
module tb_lock_client_agent;

  localparam logic [31:0] LA   = 32'd84;
  localparam int          MAXR = 3;
  localparam int          BO   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acq_req_i = 1'b0;
  logic        rel_req_i = 1'b0;
  logic        granted_o, busy_o, fail_o;
  logic [7:0]  attempts_o;
  logic [31:0] core_addr_i = '0;
  logic        core_wr_en_i = 1'b0;
  logic        core_select_i = 1'b0;
  logic [31:0] core_data_i = '0;
  logic [31:0] core_data_o;
  logic [31:0] bus_addr_o;
  logic        bus_wr_en_o, bus_select_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;

  lock_client_agent #(
    .CLIENT_ID(0), .N_CLIENTS(2), .LOCK_ADDR(LA), .BACKOFF_CYCLES(BO), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .acq_req_i(acq_req_i), .rel_req_i(rel_req_i),
    .granted_o(granted_o), .busy_o(busy_o), .fail_o(fail_o), .attempts_o(attempts_o),
    .core_addr_i(core_addr_i), .core_wr_en_i(core_wr_en_i), .core_select_i(core_select_i),
    .core_data_i(core_data_i), .core_data_o(core_data_o),
    .bus_addr_o(bus_addr_o), .bus_wr_en_o(bus_wr_en_o), .bus_select_o(bus_select_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter model: owner index, 2 = free; other_holds pretends client 1 owns it
  logic [31:0] owner = 32'd2;
  logic        other_holds = 1'b0;
  logic [31:0] periph_data = 32'h1234;
  always @(posedge clk) begin
    if (bus_select_o && bus_wr_en_o && bus_addr_o == LA) begin
      if (bus_data_o == 32'd1 && !other_holds && owner == 32'd2) owner <= 32'd0;
      else if (bus_data_o == 32'd0 && owner == 32'd0)            owner <= 32'd2;
    end
  end
  assign bus_data_i = (bus_addr_o == LA) ? (other_holds ? 32'd1 : owner) : periph_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int sampled_cyc = -1;

  // Scoreboard: every bus write observed is popped against the expected queue
  task automatic sample();
    wr_t e;
    #2;
    sampled_cyc = cyc;
    if (bus_select_o === 1'b1 && bus_wr_en_o === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_write: got addr=%h data=%h cyc=%0d, expected no write", bus_addr_o, bus_data_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus_addr_o !== e.addr || bus_data_o !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL sb_write: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                   bus_addr_o, bus_data_o, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic step();
    if (sampled_cyc != cyc) sample();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_drain(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_writes: got %0d outstanding, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({granted_o, busy_o, fail_o, attempts_o, bus_wr_en_o, bus_select_o} !== 13'd0 ||
        bus_addr_o !== 32'd0 || bus_data_o !== 32'd0 || core_data_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gr=%b busy=%b fail=%b att=%0d addr=%h wr=%b sel=%b data=%h cd=%h, expected all 0",
               granted_o, busy_o, fail_o, attempts_o, bus_addr_o, bus_wr_en_o, bus_select_o, bus_data_o, core_data_o);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    sample();
    vectors++;
    if (busy_o !== 1'b0 || granted_o !== 1'b0 || core_data_o !== 32'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b gr=%b cd=%h, expected 0 0 0", busy_o, granted_o, core_data_o);
    end
  endtask

  task automatic test_acquire(input string name);
    int t;
    t = cyc;
    acq_req_i = 1'b1;
    exp_q.push_back('{LA, 32'd1, t + 1});
    step();
    acq_req_i = 1'b0;
    sample();
    vectors++;
    if (busy_o !== 1'b1 || granted_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_req_state: got busy=%b gr=%b, expected 1 0", name, busy_o, granted_o);
    end
    step();
    sample();
    vectors++;
    if (bus_addr_o !== LA || bus_select_o !== 1'b1 || bus_wr_en_o !== 1'b0 || granted_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_check_read: got addr=%h sel=%b wr=%b gr=%b, expected %h 1 0 0",
               name, bus_addr_o, bus_select_o, bus_wr_en_o, granted_o, LA);
    end
    step();
    sample();
    vectors++;
    if (granted_o !== 1'b1 || busy_o !== 1'b0 || attempts_o !== 8'd1 || cyc != t + 3) begin
      miscompares++;
      $display("FAIL %s_granted: got gr=%b busy=%b att=%0d cyc=%0d, expected 1 0 1 cyc=%0d",
               name, granted_o, busy_o, attempts_o, cyc, t + 3);
    end
    sb_drain(name);
  endtask

  task automatic test_owned_access();
    core_addr_i   = 32'h10;
    core_wr_en_i  = 1'b1;
    core_select_i = 1'b1;
    core_data_i   = 32'hDEAD;
    exp_q.push_back('{32'h10, 32'hDEAD, cyc});
    sample();
    vectors++;
    if (bus_addr_o !== 32'h10 || bus_data_o !== 32'hDEAD || bus_wr_en_o !== 1'b1 || bus_select_o !== 1'b1) begin
      miscompares++;
      $display("FAIL owned_write_mirror: got addr=%h data=%h wr=%b sel=%b, expected 10 dead 1 1",
               bus_addr_o, bus_data_o, bus_wr_en_o, bus_select_o);
    end
    step();
    core_wr_en_i = 1'b0;
    sample();
    vectors++;
    if (core_data_o !== 32'h1234 || bus_wr_en_o !== 1'b0 || bus_select_o !== 1'b1) begin
      miscompares++;
      $display("FAIL owned_read: got cd=%h wr=%b sel=%b, expected 1234 0 1", core_data_o, bus_wr_en_o, bus_select_o);
    end
    core_addr_i   = '0;
    core_select_i = 1'b0;
    core_data_i   = '0;
    step();
    sb_drain("owned");
  endtask

  task automatic test_release();
    rel_req_i = 1'b1;
    exp_q.push_back('{LA, 32'd0, cyc + 1});
    step();
    rel_req_i = 1'b0;
    sample();
    vectors++;
    if (granted_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL release_cycle: got gr=%b busy=%b, expected 0 1", granted_o, busy_o);
    end
    step();
    sample();
    vectors++;
    if (granted_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL release_idle: got gr=%b busy=%b, expected 0 0", granted_o, busy_o);
    end
    sb_drain("release");
  endtask

  task automatic test_contended();
    int t, fails, fail_cyc;
    logic saw_grant;
    other_holds = 1'b1;
    t = cyc;
    fails = 0;
    fail_cyc = -1;
    saw_grant = 1'b0;
    acq_req_i = 1'b1;
    for (int k = 0; k < MAXR; k++) exp_q.push_back('{LA, 32'd1, t + 1 + k * (BO + 2)});
    step();
    acq_req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (fail_o === 1'b1) begin
        fails++;
        fail_cyc = cyc;
      end
      if (granted_o !== 1'b0) saw_grant = 1'b1;
      step();
    end
    vectors++;
    if (fails != 1 || fail_cyc != t + 3 * (BO + 2) - 3) begin
      miscompares++;
      $display("FAIL contended_fail_pulse: got %0d pulses last at cyc %0d, expected 1 at cyc %0d",
               fails, fail_cyc, t + 3 * (BO + 2) - 3);
    end
    vectors++;
    if (saw_grant !== 1'b0 || busy_o !== 1'b0 || attempts_o !== 8'd3) begin
      miscompares++;
      $display("FAIL contended_end: got grant_seen=%b busy=%b att=%0d, expected 0 0 3", saw_grant, busy_o, attempts_o);
    end
    sb_drain("contended");
  endtask

  task automatic test_abort_backoff();
    int fails;
    fails = 0;
    acq_req_i = 1'b1;
    exp_q.push_back('{LA, 32'd1, cyc + 1});
    step();
    acq_req_i = 1'b0;
    step();
    step();
    sample();
    vectors++;
    if (busy_o !== 1'b1 || bus_select_o !== 1'b0) begin
      miscompares++;
      $display("FAIL backoff_idle_bus: got busy=%b sel=%b, expected 1 0", busy_o, bus_select_o);
    end
    rel_req_i = 1'b1;
    step();
    rel_req_i = 1'b0;
    sample();
    vectors++;
    if (busy_o !== 1'b0 || granted_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_to_idle: got busy=%b gr=%b, expected 0 0", busy_o, granted_o);
    end
    for (int i = 0; i < 8; i++) begin
      sample();
      if (fail_o !== 1'b0) fails++;
      step();
    end
    vectors++;
    if (fails != 0) begin
      miscompares++;
      $display("FAIL abort_no_fail: got %0d fail cycles, expected 0", fails);
    end
    sb_drain("abort");
    other_holds = 1'b0;
  endtask

  task automatic test_reset_mid_owned();
    test_acquire("pre_reset");
    core_addr_i   = 32'h20;
    core_select_i = 1'b1;
    sample();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({granted_o, busy_o, fail_o, attempts_o, bus_wr_en_o, bus_select_o} !== 13'd0 ||
        bus_addr_o !== 32'd0 || bus_data_o !== 32'd0 || core_data_o !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got gr=%b busy=%b fail=%b att=%0d addr=%h sel=%b cd=%h, expected all 0",
               granted_o, busy_o, fail_o, attempts_o, bus_addr_o, bus_select_o, core_data_o);
    end
    core_addr_i   = '0;
    core_select_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    test_acquire("post_reset");
  endtask

  initial begin
    test_reset();
    test_acquire("acquire");
    test_owned_access();
    test_release();
    test_contended();
    test_abort_backoff();
    test_reset_mid_owned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
